// File: rtl/rally_controller.sv
// Game-level sequencer: serve countdown, play, miss and game-over handling.
// Tracks score, lives and ball speed and drives the ball-block restart.
module rally_controller #(
    parameter int LIVES          = 3,
    parameter int SERVE_DELAY    = 60,
    parameter int HITS_PER_LEVEL = 4,
    parameter int SPEED_INIT     = 1,
    parameter int SPEED_MAX      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       hit,
    input  logic       oob,
    output logic       ball_rst_n,
    output logic [4:0] speed,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_MISS  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_DELAY - 1);
    localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_LEVEL - 1);
    localparam logic [4:0] SPD_INIT   = 5'(SPEED_INIT);
    localparam logic [4:0] SPD_MAX    = 5'(SPEED_MAX);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [3:0] hit_cnt_q;
    logic       hit_q;
    logic [7:0] score_q;
    logic [1:0] lives_q;
    logic [4:0] speed_q;

    // A held hit flag counts only on its rising edge.
    logic hit_evt;
    assign hit_evt = hit & ~hit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            hit_cnt_q <= 4'd0;
            hit_q     <= 1'b0;
            score_q   <= 8'd0;
            lives_q   <= LIVES_INIT;
            speed_q   <= SPD_INIT;
        end else begin
            hit_q <= hit;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_q   <= S_SERVE;
                        cnt_q     <= SERVE_LOAD;
                        score_q   <= 8'd0;
                        lives_q   <= LIVES_INIT;
                        speed_q   <= SPD_INIT;
                        hit_cnt_q <= 4'd0;
                    end
                end
                S_SERVE: begin
                    if (tick) begin
                        if (cnt_q == 8'd0) state_q <= S_PLAY;
                        else               cnt_q   <= cnt_q - 8'd1;
                    end
                end
                S_PLAY: begin
                    // oob wins: a hit arriving with the miss is discarded.
                    if (oob) begin
                        state_q <= S_MISS;
                    end else if (hit_evt) begin
                        if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                        if (hit_cnt_q == HIT_LAST) begin
                            hit_cnt_q <= 4'd0;
                            if (speed_q < SPD_MAX) speed_q <= speed_q + 5'd1;
                        end else begin
                            hit_cnt_q <= hit_cnt_q + 4'd1;
                        end
                    end
                end
                S_MISS: begin
                    lives_q <= lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_q <= S_OVER;
                    end else begin
                        state_q   <= S_SERVE;
                        cnt_q     <= SERVE_LOAD;
                        speed_q   <= SPD_INIT;
                        hit_cnt_q <= 4'd0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state      = state_q;
    assign ball_rst_n = (state_q == S_PLAY);
    assign game_over  = (state_q == S_OVER);
    assign score      = score_q;
    assign lives      = lives_q;
    assign speed      = speed_q;

endmodule
